// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
// Loads hit in zero cycles; misses refill a full line over a req/ack port.
`timescale 1ns/1ps
module dcache_ctrl #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t              state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_LINES];
    logic [31:0]         data_q [NUM_LINES][WORDS_PER_LINE];
    logic [OFF_W-1:0]    cnt_q;
    logic [OFF_W-1:0]    cnt_d;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;

    assign off = cpu_addr[OFF_W-1:0];
    assign idx = cpu_addr[OFF_W+IDX_W-1:OFF_W];
    assign tag = cpu_addr[31:OFF_W+IDX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);
    assign cnt_d = cnt_q + OFF_W'(1);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Hit data path and pipeline stall; only a load hit in IDLE avoids stalling.
    always_comb begin
        cpu_rdata = hit ? data_q[idx][off] : 32'h0;
        cpu_stall = 1'b0;
        unique case (state_q)
            IDLE:   cpu_stall = cpu_req && (cpu_we || !hit);
            REFILL: cpu_stall = 1'b1;
            WRITE:  cpu_stall = 1'b1;
            DONE:   cpu_stall = 1'b0;
            default: cpu_stall = 1'b0;
        endcase
    end

    // Control FSM with registered memory-port outputs and line valid bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_req && cpu_we) begin
                        state_q     <= WRITE;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cpu_addr;
                        mem_wdata_q <= cpu_wdata;
                    end else if (cpu_req && !hit) begin
                        state_q      <= REFILL;
                        valid_q[idx] <= 1'b0;
                        cnt_q        <= '0;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= {tag, idx, {OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        if (cnt_q == LAST) begin
                            valid_q[idx] <= 1'b1;
                            mem_req_q    <= 1'b0;
                            state_q      <= DONE;
                        end else begin
                            cnt_q      <= cnt_d;
                            mem_addr_q <= {tag, idx, cnt_d};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage: refill words, tag on the last word, write-through hit update.
    always_ff @(posedge clock) begin
        if (state_q == REFILL && mem_ack) begin
            data_q[idx][cnt_q] <= mem_rdata;
            if (cnt_q == LAST) begin
                tag_q[idx] <= tag;
            end
        end
        if (state_q == WRITE && mem_ack && hit) begin
            data_q[idx][off] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl.
// Driver pushes expected memory transactions and load data; monitor pops and compares.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    dcache_ctrl dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected memory transactions and load results
    logic [31:0] em_addr [1024];
    logic [31:0] em_wd   [1024];
    logic        em_we   [1024];
    int          em_wr = 0;
    int          em_rd = 0;
    logic [31:0] er_val  [1024];
    int          er_wr = 0;
    int          er_rd = 0;

    // Memory contents: dmem seen by the responder, ref_mem by the driver
    logic [31:0] dmem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] touched [$];

    // Cache model: which tag each line should hold
    bit          mvalid [16];
    logic [25:0] mtag   [16];

    int lat_fix = 2;
    bit rand_lat = 1'b0;
    bit stray = 1'b0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a >= 32'h40 && a <= 32'h43) return 32'hA0 + (a - 32'h40);
        return 32'h5EED_0000 ^ (a * 32'h0001_0003);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Memory responder and monitor for memory-port and load-retire events
    int          wcnt = 0;
    int          lat_cur = 1;
    logic        p_req = 1'b0;
    logic        p_hs = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wd = '0;

    always @(negedge clock) begin
        if (reset) begin
            mem_ack = 1'b0;
            wcnt = 0;
            p_req = 1'b0;
            p_hs = 1'b0;
        end else begin
            if (p_req && !p_hs) begin
                n_cmp++;
                if (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd) begin
                    n_bad++;
                    $display("FAIL mem_hold: got req=%b addr=%h we=%b wd=%h required req=1 addr=%h we=%b wd=%h",
                             mem_req, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wd);
                end
            end
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (stray) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
            end else if (mem_req) begin
                if (wcnt == 0) lat_cur = rand_lat ? int'($urandom_range(1, 5)) : lat_fix;
                wcnt++;
                if (wcnt >= lat_cur) begin
                    wcnt = 0;
                    mem_ack = 1'b1;
                    if (em_rd >= em_wr) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL mem_unexpected: got addr=%h we=%b required no request", mem_addr, mem_we);
                    end else begin
                        chk("mem_addr", mem_addr, em_addr[em_rd]);
                        chk("mem_we", {31'b0, mem_we}, {31'b0, em_we[em_rd]});
                        if (em_we[em_rd]) chk("mem_wdata", mem_wdata, em_wd[em_rd]);
                        em_rd++;
                    end
                    if (mem_we) dmem[mem_addr] = mem_wdata;
                    mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : init_val(mem_addr);
                end
            end
            p_req = mem_req;
            p_we = mem_we;
            p_addr = mem_addr;
            p_wd = mem_wdata;
            p_hs = mem_ack;
            if (cpu_req && !cpu_we && !cpu_stall) begin
                if (er_rd >= er_wr) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL load_unexpected: got rdata=%h addr=%h required no retire", cpu_rdata, cpu_addr);
                end else begin
                    chk("load_rdata", cpu_rdata, er_val[er_rd]);
                    er_rd++;
                end
            end
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] d);
        em_addr[em_wr] = a;
        em_we[em_wr] = we;
        em_wd[em_wr] = d;
        em_wr++;
    endtask

    task automatic wait_retire(input bit exp_hit, input string nm);
        int k = 0;
        @(negedge clock);
        chk({nm, "_stall"}, {31'b0, cpu_stall}, {31'b0, !exp_hit});
        while (cpu_stall && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (cpu_stall) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got stall=1 after %0d cycles required 0", nm, k);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input string nm);
        logic [3:0]  ix = a[5:2];
        logic [25:0] tg = a[31:6];
        bit          hit = mvalid[ix] && (mtag[ix] == tg);
        if (!hit) begin
            for (int i = 0; i < 4; i++) push_mem({a[31:2], 2'(i)}, 1'b0, 32'h0);
            mvalid[ix] = 1'b1;
            mtag[ix] = tg;
        end
        er_val[er_wr] = exp;
        er_wr++;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = a;
        cpu_wdata = '0;
        wait_retire(hit, nm);
        cpu_req = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string nm);
        push_mem(a, 1'b1, d);
        ref_mem[a] = d;
        touched.push_back(a);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        wait_retire(1'b0, nm);
        cpu_req = 1'b0;
        cpu_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int k;
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Test 1: refill then zero-latency hit
        lat_fix = 2;
        do_load(32'h40, 32'hA0, "t1_miss");
        do_load(32'h42, 32'hA2, "t1_hit");

        // Test 2: store hit updates line
        do_store(32'h41, 32'hDEAD, "t2_store");
        do_load(32'h41, 32'hDEAD, "t2_hit");

        // Test 3: store miss does not allocate
        do_store(32'h80, 32'h1234_5678, "t3_store");
        do_load(32'h80, 32'h1234_5678, "t3_miss");

        // Test 4: aliasing lines replace each other
        do_load(32'h40, 32'hA0, "t4_a");
        do_load(32'h140, init_val(32'h140), "t4_b");
        do_load(32'h40, 32'hA0, "t4_c");

        // Test 5: reset during second refill word, then a stray ack
        lat_fix = 3;
        push_mem(32'h140, 1'b0, 32'h0);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h140;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(mem_req && mem_addr == 32'h141) && k < 100);
        chk("t5_reach_word1", mem_addr, 32'h141);
        #1 reset = 1'b1;
        #1 chk("t5_req_drop", {31'b0, mem_req}, 32'h0);
        cpu_req = 1'b0;
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1 stray = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1 stray = 1'b0;
        chk("t5_stray_req", {31'b0, mem_req}, 32'h0);
        @(negedge clock);
        chk("t5_stray_stall", {31'b0, cpu_stall}, 32'h0);
        chk("t5_stray_req2", {31'b0, mem_req}, 32'h0);
        @(posedge clock);
        #1;
        do_load(32'h40, 32'hA0, "t5_reload");

        // Test 6: random stream with random ack latency
        rand_lat = 1'b1;
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 2)) << 8) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_store(a, d, "t6_store");
            end else begin
                touched.push_back(a);
                do_load(a, ref_rd(a), "t6_load");
            end
        end

        repeat (4) @(posedge clock);
        #1;
        chk("mem_queue_drained", 32'(em_rd), 32'(em_wr));
        chk("load_queue_drained", 32'(er_rd), 32'(er_wr));
        foreach (touched[i]) begin
            a = touched[i];
            chk("mem_contents", dmem.exists(a) ? dmem[a] : init_val(a), ref_rd(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
